bitnet_requant: RTL and testbench

- Downstream stage of the ternary-weight FMA accumulators.
- Consumes the saturated signed 16-bit accumulator values they produce and requantizes each to a signed int8 activation for the next layer.
- Per-channel processing: scale multiply, round-half-up arithmetic right shift, optional ReLU, clamp to int8.
- 3-stage pipeline with valid/ready handshake and a per-channel config table.

---
 rtl/bitnet_requant_if.sv | 33 +++
 rtl/bitnet_requant.sv | 124 ++++++++++++
 tb/tb_bitnet_requant.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bitnet_requant_if.sv
// rtl/bitnet_requant_if.sv - config, accumulator-in and int8-out signal bundle for bitnet_requant
interface bitnet_requant_if #(
  parameter int CW = 4
);
  logic          cfg_we;
  logic [CW-1:0] cfg_addr;
  logic [15:0]   cfg_scale;
  logic [4:0]    cfg_shift;
  logic          cfg_relu;

  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_acc;
  logic          in_last;

  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic          out_last;
  logic [CW-1:0] out_ch;

  modport master (
    output cfg_we, cfg_addr, cfg_scale, cfg_shift, cfg_relu,
    output in_valid, in_acc, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_ch
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_scale, cfg_shift, cfg_relu,
    input  in_valid, in_acc, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_ch
  );
endinterface

// File: rtl/bitnet_requant.sv
// rtl/bitnet_requant.sv - 3-stage per-channel requantizer: scale, round-half-up shift, relu, int8 clamp
module bitnet_requant #(
  parameter int NUM_CH = 16,
  parameter int CW     = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  bitnet_requant_if.slave   bus
);
  logic [15:0] scale_tab [NUM_CH];
  logic [4:0]  shift_tab [NUM_CH];
  logic        relu_tab  [NUM_CH];

  logic [CW-1:0] ch;
  logic          en;
  logic          accept;

  logic                 s1_valid, s1_relu, s1_last;
  logic signed [32:0]   s1_p;
  logic [4:0]           s1_shift;
  logic [CW-1:0]        s1_ch;

  logic                 s2_valid, s2_relu, s2_last;
  logic signed [33:0]   s2_r;
  logic [CW-1:0]        s2_ch;

  logic                 out_valid_q, out_last_q;
  logic [7:0]           out_data_q;
  logic [CW-1:0]        out_ch_q;

  logic signed [32:0]   acc_ext, scl_ext, prod;
  logic signed [33:0]   p_ext, rnd, r_next, r_relu;
  logic [7:0]           q_next;

  // One enable for the whole pipe: bubbles advance too, so latency is fixed in en-cycles.
  assign en     = !out_valid_q || bus.out_ready;
  assign accept = bus.in_valid && en;

  assign bus.in_ready  = en;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_ch    = out_ch_q;

  assign acc_ext = {{17{bus.in_acc[15]}}, bus.in_acc};
  assign scl_ext = {17'd0, scale_tab[ch]};
  assign prod    = acc_ext * scl_ext;

  always_comb begin
    p_ext  = {s1_p[32], s1_p};
    rnd    = (s1_shift == 5'd0) ? 34'sd0 : (34'sd1 <<< (s1_shift - 5'd1));
    r_next = (p_ext + rnd) >>> s1_shift;
  end

  always_comb begin
    r_relu = (s2_relu && (s2_r < 34'sd0)) ? 34'sd0 : s2_r;
    if (r_relu > 34'sd127) begin
      q_next = 8'h7f;
    end else if (r_relu < -34'sd128) begin
      q_next = 8'h80;
    end else begin
      q_next = r_relu[7:0];
    end
  end

  // Table writes land at the edge, so a same-cycle acceptance still reads the old entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        scale_tab[i] <= 16'd1;
        shift_tab[i] <= 5'd0;
        relu_tab[i]  <= 1'b0;
      end
    end else if (bus.cfg_we) begin
      scale_tab[bus.cfg_addr] <= bus.cfg_scale;
      shift_tab[bus.cfg_addr] <= bus.cfg_shift;
      relu_tab[bus.cfg_addr]  <= bus.cfg_relu;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ch <= '0;
    end else if (accept) begin
      ch <= bus.in_last ? '0 : ch + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      s1_p        <= '0;
      s1_shift    <= '0;
      s1_relu     <= 1'b0;
      s1_last     <= 1'b0;
      s1_ch       <= '0;
      s2_valid    <= 1'b0;
      s2_r        <= '0;
      s2_relu     <= 1'b0;
      s2_last     <= 1'b0;
      s2_ch       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
    end else if (en) begin
      s1_valid    <= accept;
      s1_p        <= prod;
      s1_shift    <= shift_tab[ch];
      s1_relu     <= relu_tab[ch];
      s1_last     <= bus.in_last;
      s1_ch       <= ch;
      s2_valid    <= s1_valid;
      s2_r        <= r_next;
      s2_relu     <= s1_relu;
      s2_last     <= s1_last;
      s2_ch       <= s1_ch;
      out_valid_q <= s2_valid;
      out_data_q  <= q_next;
      out_last_q  <= s2_last;
      out_ch_q    <= s2_ch;
    end
  end
endmodule

// File: tb/tb_bitnet_requant.sv
// tb/tb_bitnet_requant.sv - table, directed and randomized scoreboard bench for bitnet_requant
module tb_bitnet_requant;
  localparam int NUM_CH = 16;
  localparam int CW     = 4;

  logic clk;
  logic reset;

  bitnet_requant_if #(.CW(CW)) bus ();

  bitnet_requant #(.NUM_CH(NUM_CH), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int data;
    int ch;
    bit last;
    int en_at;
  } exp_t;

  typedef struct {
    int scale;
    int shift;
    bit relu;
    int acc;
    int exp;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  int   m_scale [NUM_CH];
  int   m_shift [NUM_CH];
  bit   m_relu  [NUM_CH];
  int   m_ch;
  int   en_edges = 0;
  int   last_data;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  // Reference: exact rational value, rounded half toward +inf, then relu and clamp.
  function automatic int ref_q(input int acc, input int scale, input int sh, input bit relu);
    real v;
    v = $floor(real'(acc) * real'(scale) / real'(longint'(1) << sh) + 0.5);
    if (relu && v < 0.0) v = 0.0;
    if (v > 127.0) v = 127.0;
    if (v < -128.0) v = -128.0;
    return int'(v);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      q.delete();
      m_ch = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_scale[i] = 1;
        m_shift[i] = 0;
        m_relu[i]  = 1'b0;
      end
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = q.pop_front();
          last_data = int'($signed(bus.out_data));
          chk("out_data", last_data, e.data);
          chk("out_ch", bus.out_ch, e.ch);
          chk("out_last", bus.out_last, e.last);
          chk("latency", en_edges - e.en_at, 3);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        e.data  = ref_q(int'($signed(bus.in_acc)), m_scale[m_ch], m_shift[m_ch], m_relu[m_ch]);
        e.ch    = m_ch;
        e.last  = bus.in_last;
        e.en_at = en_edges;
        q.push_back(e);
        m_ch = bus.in_last ? 0 : (m_ch + 1) % NUM_CH;
      end
      if (bus.cfg_we) begin
        m_scale[bus.cfg_addr] = int'(bus.cfg_scale);
        m_shift[bus.cfg_addr] = int'(bus.cfg_shift);
        m_relu[bus.cfg_addr]  = bus.cfg_relu;
      end
      if (!bus.out_valid || bus.out_ready) en_edges++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic cfg_write(input int a, input int s, input int sh, input bit r);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = CW'(a);
    bus.cfg_scale = 16'(s);
    bus.cfg_shift = 5'(sh);
    bus.cfg_relu  = r;
    tick();
    bus.cfg_we    = 1'b0;
  endtask

  task automatic send(input int a, input bit l);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_acc   = 16'(a);
    bus.in_last  = l;
    @(negedge clk);
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("send_timeout", 1, 0);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 200) begin
      tick();
      t++;
    end
    chk("drain_pending", q.size(), 0);
  endtask

  vec_t tbl[$];

  initial begin
    bit acc_now;
    int held;
    int t;
    reset = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_scale = '0; bus.cfg_shift = '0; bus.cfg_relu = 1'b0;
    bus.in_valid = 1'b0; bus.in_acc = '0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_out_ch", bus.out_ch, 0);
    chk("rst_in_ready", bus.in_ready, 1);

    // Identity config after reset, back-to-back with the scoreboard checking latency.
    send(100, 0);
    send(300, 0);
    send(-32768, 0);
    drain();
    chk("identity_last", last_data, -128);

    tbl.push_back('{1, 0, 0, 100, 100});
    tbl.push_back('{1, 0, 0, 300, 127});
    tbl.push_back('{1, 0, 0, -32768, -128});
    tbl.push_back('{3, 2, 0, 10, 8});
    tbl.push_back('{3, 2, 0, -10, -7});
    tbl.push_back('{1, 1, 0, -1, 0});
    tbl.push_back('{1, 1, 0, 15, 8});
    tbl.push_back('{1, 1, 0, -15, -7});
    tbl.push_back('{1, 0, 1, -50, 0});
    tbl.push_back('{65535, 16, 0, 32767, 127});
    tbl.push_back('{65535, 16, 0, -32768, -128});
    tbl.push_back('{1, 31, 0, -32768, 0});
    tbl.push_back('{4, 3, 1, 20, 10});
    do_reset();
    foreach (tbl[i]) begin
      cfg_write(0, tbl[i].scale, tbl[i].shift, tbl[i].relu);
      send(tbl[i].acc, 1);
      drain();
      chk($sformatf("table_%0d", i), last_data, tbl[i].exp);
    end

    // Backpressure: 6 back-to-back items, 4-cycle stall after the first output.
    do_reset();
    fork
      begin
        for (int i = 0; i < 6; i++) send(i * 20 - 50, 0);
      end
      begin
        t = 0;
        @(negedge clk);
        while (!bus.out_valid && t < 20) begin
          @(negedge clk);
          t++;
        end
        if (t >= 20) chk("first_valid_timeout", 1, 0);
        tick();
        bus.out_ready = 1'b0;
        held = int'(bus.out_data);
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("stall_in_ready", bus.in_ready, 0);
          chk("stall_out_valid", bus.out_valid, 1);
          chk("stall_out_data", bus.out_data, held);
        end
        tick();
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Channel sequencing: wrap, then in_last on the 5th input.
    do_reset();
    for (int i = 0; i < 20; i++) send(i, 0);
    drain();
    do_reset();
    for (int i = 0; i < 10; i++) send(i + 1, i == 4);
    drain();

    // Randomized traffic with stalls and config writes.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      acc_now = bus.in_valid && bus.in_ready;
      tick();
      if (!bus.in_valid || acc_now) begin
        bus.in_valid = $urandom_range(0, 3) != 0;
        bus.in_acc   = 16'($urandom);
        bus.in_last  = $urandom_range(0, 7) == 0;
      end
      bus.out_ready = $urandom_range(0, 3) != 0;
      bus.cfg_we    = $urandom_range(0, 7) == 0;
      bus.cfg_addr  = CW'($urandom);
      bus.cfg_scale = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 8));
      bus.cfg_shift = 5'($urandom);
      bus.cfg_relu  = 1'($urandom);
    end
    tick();
    bus.in_valid  = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    // Reset with three items in flight and the output stalled.
    cfg_write(0, 2, 0, 0);
    bus.out_ready = 1'b0;
    send(7, 0);
    send(8, 0);
    send(9, 0);
    reset = 1'b1;
    tick();
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    send(50, 0);
    drain();
    chk("midrst_data", last_data, 50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
